// File: rtl/cla8_addsub_pipe.sv
// Two-stage pipelined adder/subtractor built from 4-bit carry-lookahead groups.
// Stage 1 resolves the low half and its carry; stage 2 the high half, carry-out and overflow.
module cla8_addsub_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic [15:0]      ops_done
);

  localparam int HALF = WIDTH / 2;
  localparam int NGRP = HALF / 4;

  // Fully expanded lookahead inside one group; bit k is the carry into bit k+1.
  function automatic logic [3:0] cla4_carry(input logic [3:0] g, input logic [3:0] p,
                                            input logic cin);
    logic [3:0] c;
    c[0] = g[0] | (p[0] & cin);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[3] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return c;
  endfunction

  // One half-width adder made of lookahead groups; returns {carry_out, sum}.
  function automatic logic [HALF:0] half_add(input logic [HALF-1:0] x,
                                             input logic [HALF-1:0] y,
                                             input logic cin);
    logic [HALF-1:0] g;
    logic [HALF-1:0] p;
    logic [HALF:0]   c;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = cin;
    for (int k = 0; k < NGRP; k++) begin
      c[4*k+1 +: 4] = cla4_carry(g[4*k +: 4], p[4*k +: 4], c[4*k]);
    end
    return {c[HALF], p ^ c[HALF-1:0]};
  endfunction

  logic [WIDTH-1:0] b_eff_s;
  logic [HALF:0]    lo_res_s;
  logic [HALF:0]    hi_res_s;
  logic             c_msb_s;
  logic             s2_adv_s;
  logic             s1_adv_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             s2_load_s;
  logic             out_fire_s;

  logic             s1_valid_r;
  logic [HALF-1:0]  s1_sum_lo_r;
  logic             s1_c_lo_r;
  logic [HALF-1:0]  s1_a_hi_r;
  logic [HALF-1:0]  s1_b_hi_r;

  logic             s2_valid_r;
  logic [WIDTH-1:0] s2_sum_r;
  logic             s2_cout_r;
  logic             s2_ovf_r;
  logic [15:0]      ops_done_r;

  // Operand transform and both half adders.
  always_comb begin
    b_eff_s = b;
    if (sub) begin
      b_eff_s = ~b;
    end else begin
      b_eff_s = b;
    end
    lo_res_s = half_add(a[HALF-1:0], b_eff_s[HALF-1:0], sub);
    hi_res_s = half_add(s1_a_hi_r, s1_b_hi_r, s1_c_lo_r);
    // Carry into the MSB recovered from its sum bit: s = p ^ c.
    c_msb_s  = hi_res_s[HALF-1] ^ s1_a_hi_r[HALF-1] ^ s1_b_hi_r[HALF-1];
  end

  // Valid/ready handshake between the two stages.
  always_comb begin
    s2_adv_s   = ~s2_valid_r | out_ready;
    s1_adv_s   = ~s1_valid_r | s2_adv_s;
    in_ready_s = s1_adv_s & ~rst;
    accept_s   = in_valid & in_ready_s;
    s2_load_s  = s2_adv_s & s1_valid_r;
    out_fire_s = s2_valid_r & out_ready;
  end

  // Stage 1: low-half result plus the high-half operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_sum_lo_r <= '0;
      s1_c_lo_r   <= 1'b0;
      s1_a_hi_r   <= '0;
      s1_b_hi_r   <= '0;
    end else if (accept_s) begin
      s1_valid_r  <= 1'b1;
      s1_sum_lo_r <= lo_res_s[HALF-1:0];
      s1_c_lo_r   <= lo_res_s[HALF];
      s1_a_hi_r   <= a[WIDTH-1:HALF];
      s1_b_hi_r   <= b_eff_s[WIDTH-1:HALF];
    end else if (s2_load_s) begin
      s1_valid_r  <= 1'b0;
    end
  end

  // Stage 2: full result, carry-out and signed overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r <= 1'b0;
      s2_sum_r   <= '0;
      s2_cout_r  <= 1'b0;
      s2_ovf_r   <= 1'b0;
    end else if (s2_load_s) begin
      s2_valid_r <= 1'b1;
      s2_sum_r   <= {hi_res_s[HALF-1:0], s1_sum_lo_r};
      s2_cout_r  <= hi_res_s[HALF];
      s2_ovf_r   <= hi_res_s[HALF] ^ c_msb_s;
    end else if (out_ready) begin
      s2_valid_r <= 1'b0;
    end
  end

  // Completed-handshake counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_done_r <= 16'h0000;
    end else if (out_fire_s) begin
      ops_done_r <= ops_done_r + 16'h0001;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = s2_valid_r;
  assign sum       = s2_sum_r;
  assign cout      = s2_cout_r;
  assign ovf       = s2_ovf_r;
  assign ops_done  = ops_done_r;

endmodule

// File: tb/tb_cla8_addsub_pipe.sv
// Self-checking bench for cla8_addsub_pipe: directed vector table, backpressure,
// mid-flight reset and a long random stream that wraps the handshake counter.
module tb_cla8_addsub_pipe;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  localparam int NSTREAM = 65537;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic [15:0] ops_done;

  int total = 0;
  int bad   = 0;

  vec_t vecs[10];

  cla8_addsub_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .ops_done(ops_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference built from signed/unsigned integer arithmetic: {cout, ovf, sum}.
  function automatic logic [9:0] ref_model(input logic [7:0] x, input logic [7:0] y,
                                           input logic s);
    int ux, uy, sx, sy, res;
    logic c, v;
    logic [7:0] r;
    ux = int'(x);
    uy = int'(y);
    sx = (ux > 127) ? ux - 256 : ux;
    sy = (uy > 127) ? uy - 256 : uy;
    if (s) begin
      res = sx - sy;
      c   = (ux >= uy);
      r   = 8'((ux - uy + 256) % 256);
    end else begin
      res = sx + sy;
      c   = ((ux + uy) > 255);
      r   = 8'((ux + uy) % 256);
    end
    v = (res > 127) || (res < -128);
    return {c, v, r};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int sent, rcv, cyc, s_err, o_err;
    bit chk0;
    logic [9:0] expq[$];
    logic [9:0] cur_exp;
    logic [9:0] e;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[5] = '{8'h33, 8'h33, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[7] = '{8'h00, 8'h01, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[8] = '{8'h7F, 8'hFF, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[9] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0};

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_ops_done", 32'(ops_done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Directed vectors, one at a time, checking two-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      a = vecs[i].a; b = vecs[i].b; sub = vecs[i].sub; in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("v%0d_early_valid", i), 32'(out_valid), 32'd0);
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d_sum", i), 32'(sum), 32'(vecs[i].sum));
      check($sformatf("v%0d_cout", i), 32'(cout), 32'(vecs[i].cout));
      check($sformatf("v%0d_ovf", i), 32'(ovf), 32'(vecs[i].ovf));
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("vec_ops_done", 32'(ops_done), 32'd10);
    check("vec_drained", 32'(out_valid), 32'd0);

    // Backpressure: three offered, two accepted, then drained in order
    do_reset();
    out_ready = 1'b0;
    sub = 1'b0;
    @(posedge clk); #1;
    a = 8'h01; b = 8'h01; in_valid = 1'b1;
    @(negedge clk);
    check("bp_ready1", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    a = 8'h02; b = 8'h02;
    @(negedge clk);
    check("bp_ready2", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    a = 8'h03; b = 8'h03;
    @(negedge clk);
    check("bp_full_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_still_full", 32'(in_ready), 32'd0);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_hold_sum", 32'(sum), 32'h02);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_out0", 32'(sum), 32'h02);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_valid1", 32'(out_valid), 32'd1);
    check("bp_out1", 32'(sum), 32'h04);
    @(negedge clk);
    check("bp_valid2", 32'(out_valid), 32'd1);
    check("bp_out2", 32'(sum), 32'h06);
    @(negedge clk);
    check("bp_empty", 32'(out_valid), 32'd0);
    check("bp_ops_done", 32'(ops_done), 32'd3);

    // Reset with both stages full
    out_ready = 1'b0;
    @(posedge clk); #1;
    a = 8'h10; b = 8'h20; in_valid = 1'b1;
    @(posedge clk); #1;
    a = 8'h30; b = 8'h40;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("mr_full_valid", 32'(out_valid), 32'd1);
    check("mr_full_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mr_ready_in_rst", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_ops_done", 32'(ops_done), 32'd0);
    check("mr_sum", 32'(sum), 32'd0);
    check("mr_ready_after", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("mr_no_stale%0d", k), 32'(out_valid), 32'd0);
    end

    // Long random stream with out_ready held high
    do_reset();
    out_ready = 1'b1;
    sent = 0; rcv = 0; cyc = 0; s_err = 0; o_err = 0; chk0 = 1'b0;
    cur_exp = '0;
    @(posedge clk); #1;
    a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
    cur_exp = ref_model(a, b, sub);
    in_valid = 1'b1;
    while (rcv < NSTREAM && cyc < 70000) begin
      @(negedge clk);
      if (ops_done !== rcv[15:0]) o_err++;
      if (rcv == 65536 && !chk0) begin
        check("ops_done_wrap0", 32'(ops_done), 32'h0000);
        chk0 = 1'b1;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          s_err++;
        end else begin
          e = expq.pop_front();
          if ({cout, ovf, sum} !== e) begin
            if (s_err < 5) $display("stream result %0d: got %h expected %h", rcv, {cout, ovf, sum}, e);
            s_err++;
          end
        end
        rcv++;
      end
      if (in_valid && in_ready) begin
        expq.push_back(cur_exp);
        sent++;
      end
      @(posedge clk); #1;
      if (sent < NSTREAM) begin
        a = 8'($urandom); b = 8'($urandom); sub = 1'($urandom);
        cur_exp = ref_model(a, b, sub);
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      cyc++;
    end
    @(negedge clk);
    check("stream_count", 32'(rcv), 32'(NSTREAM));
    check("stream_results", 32'(s_err), 32'd0);
    check("stream_ops_track", 32'(o_err), 32'd0);
    check("stream_wrap0_seen", 32'(chk0), 32'd1);
    check("ops_done_wrap1", 32'(ops_done), 32'h0001);
    check("stream_empty", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
